apb_uart_host_arb: RTL
======================

Name: apb_uart_host_arb

Overview:
APB4 master that shares the apb_uart register file between NUM_REQ independent requesters, for example a TX streamer and a CPU config port.
- Arbitrates requests round-robin.
- Runs exactly one APB transfer at a time (SETUP -> ACCESS, honouring pready).
- Returns read data and error to the granted requester.
- Sits between on-chip requesters and the apb_interface master side of apb_uart.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 12, APB address width (matches paddr of apb_uart)
DATA_W, 32, APB data width
TIMEOUT_CYCLES, 16, ACCESS wait-state limit (used only with the optional feature)

Ports:
pclk  in  1  APB clock
preset_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_strb  in  NUM_REQ*4  packed byte strobes
resp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
resp_rdata  out  DATA_W  read data; 0 for writes
resp_err  out  1  pslverr (or timeout) of the completed transfer
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  4  APB strobes
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset: clock pclk, synchronous active-low preset_n, sampled on the rising edge.
  - psel, penable, pwrite, resp_valid, resp_err = 0.
  - paddr, pwdata, pstrb, resp_rdata = 0.
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE -> SETUP on accept.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE when pready = 1.
  - ACCESS stays in ACCESS while pready = 0.
- Arbitration (IDLE only):
  - Grant goes to the first requester with req_valid = 1, scanning from last_grant+1 upward with wrap-around.
  - req_ready[g] is combinational: high only in IDLE for the granted requester. Accept = req_valid[g] & req_ready[g].
  - req_ready is all zero in SETUP and ACCESS.
- On accept (registered at the edge):
  - last_grant <= g.
  - paddr, pwrite, pwdata latched from requester g.
  - pstrb <= req_strb for writes; pstrb <= 0 for reads (APB4 rule).
  - psel <= 1, penable <= 0.
- SETUP: penable <= 1 at the edge leaving SETUP.
- ACCESS:
  - paddr, pwdata, pwrite, pstrb held stable.
  - Transfer completes on the edge where pready = 1. At that edge:
    - psel and penable <= 0.
    - resp_valid[g] <= 1 for exactly one cycle.
    - resp_rdata <= prdata for reads, 0 for writes.
    - resp_err <= pslverr.
- Latency: accept at cycle 0, psel = 1 in cycle 1, penable = 1 in cycle 2. With pready = 1 in cycle 2, resp_valid = 1 in cycle 3. Each wait state adds 1 cycle.
- Throughput: the cycle carrying resp_valid is IDLE, so a new request can be accepted in it. Back-to-back transfers take 3 cycles each.
- resp_rdata and resp_err hold their value until the next completion.
- req_valid dropped before accept: no transfer, no state change. Request fields are sampled only at accept and may change afterwards.
- Reset asserted mid-SETUP or mid-ACCESS: at that edge psel and penable drop to 0; no resp_valid is issued; arbitration restarts with requester 0.
- pslverr is ignored while pready = 0.

Optional Feature:
APB_UART_ARB_TIMEOUT_EN
- Defined:
  - Counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entering ACCESS and increments each ACCESS cycle with pready = 0.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted on that edge: psel and penable <= 0, resp_valid[g] <= 1, resp_err <= 1, resp_rdata <= 0, state -> IDLE.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write, pready = 1: req0 writes ADDR_TDR, data 0xA5A5A5A5, strb 0x1 -> psel = 1 in cycle 1, penable = 1 in cycle 2, paddr = ADDR_TDR, pwdata = 0xA5A5A5A5, pstrb = 0x1; resp_valid[0] in cycle 3; resp_err = 0; resp_rdata = 0.
- Read with 2 wait states: req1 reads ADDR_TDR; pready low for 2 ACCESS cycles, then high with prdata = 0x000000A5 -> pstrb = 0; penable held 3 cycles; resp_valid[1] in cycle 5; resp_rdata = 0x000000A5.
- Contention: req0 and req1 both valid continuously from reset, 4 transfers each -> grant order 0,1,0,1,...; every transfer 3 cycles apart; psel never drops except between transfers.
- Slave error: pslverr = 1 with pready = 1 on a write -> resp_err = 1 with resp_valid[0]; next transfer proceeds normally.
- Reset mid-ACCESS: preset_n = 0 for 1 cycle while penable = 1 -> psel = penable = 0 at that edge; no resp_valid; after release, req1 and req0 both valid -> req0 granted first.
- Timeout (with APB_UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): pready held 0 -> abort after 16 ACCESS wait cycles; resp_err = 1; resp_rdata = 0; IDLE next cycle. Without the macro, psel and penable stay high after 100 cycles.

Source files
------------

// File: rtl/apb_uart_host_arb_if.sv
// APB4 bus bundle between apb_uart_host_arb and the apb_uart register file.
//   master modport : arbiter side, drives psel/penable/pwrite/paddr/pwdata/pstrb,
//                    receives prdata/pready/pslverr.
//   slave modport  : register-file side, the mirror image.
interface apb_uart_host_arb_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_uart_host_arb.sv
// Round-robin APB4 master sharing the apb_uart register file among NUM_REQ requesters.
// One APB transfer in flight at a time (SETUP -> ACCESS, waits on pready).
//
// Ports:
//   pclk, preset_n        clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero, IDLE only
//   req_write/addr/wdata/strb  packed request fields, requester i in slice i
//   resp_valid            one-cycle completion pulse to the owning requester
//   resp_rdata/resp_err   result of the last completed transfer, held until the next one
//   apb                   APB4 master modport (psel, penable, pwrite, paddr, pwdata, pstrb,
//                         prdata, pready, pslverr)
//
// Optional feature: define APB_UART_ARB_TIMEOUT_EN to abort an ACCESS phase with resp_err
// after TIMEOUT_CYCLES wait states. Without it ACCESS waits for pready indefinitely.
module apb_uart_host_arb #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_strb,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    apb_uart_host_arb_if.master       apb
);

    localparam int unsigned GrantW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : gen_param_check
        $error("apb_uart_host_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    // Doubles as the owner of the transfer in flight.
    logic [GrantW-1:0] last_grant_q, last_grant_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

`ifdef APB_UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    // Abort on the edge where the counter would reach TIMEOUT_CYCLES.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    // Round-robin pick: first valid requester scanning from last_grant+1 with wrap-around.
    logic              arb_found;
    logic [GrantW-1:0] arb_grant;
    logic              arb_write;
    logic [ADDR_W-1:0] arb_addr;
    logic [DATA_W-1:0] arb_wdata;
    logic [3:0]        arb_strb;

    always_comb begin
        arb_found = 1'b0;
        arb_grant = '0;
        arb_write = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        arb_strb  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!arb_found && req_valid[j] &&
                    j == (32'(last_grant_q) + off) % NUM_REQ) begin
                    arb_found = 1'b1;
                    arb_grant = GrantW'(j);
                    arb_write = req_write[j];
                    arb_addr  = req_addr[j*ADDR_W +: ADDR_W];
                    arb_wdata = req_wdata[j*DATA_W +: DATA_W];
                    arb_strb  = req_strb[j*4 +: 4];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && arb_found) begin
            req_ready[arb_grant] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef APB_UART_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                // req_ready is only driven for the pick, so a pick here is an accept.
                if (arb_found) begin
                    state_d      = StSetup;
                    last_grant_d = arb_grant;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    pwrite_d     = arb_write;
                    paddr_d      = arb_addr;
                    pwdata_d     = arb_wdata;
                    // APB4: strobes must be low on reads.
                    pstrb_d      = arb_write ? arb_strb : 4'h0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
`ifdef APB_UART_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            StAccess: begin
                if (apb.pready) begin
                    state_d                    = StIdle;
                    psel_d                     = 1'b0;
                    penable_d                  = 1'b0;
                    resp_valid_d[last_grant_q] = 1'b1;
                    resp_rdata_d               = pwrite_q ? '0 : apb.prdata;
                    resp_err_d                 = apb.pslverr;
                end
`ifdef APB_UART_ARB_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    state_d                    = StIdle;
                    psel_d                     = 1'b0;
                    penable_d                  = 1'b0;
                    resp_valid_d[last_grant_q] = 1'b1;
                    resp_rdata_d               = '0;
                    resp_err_d                 = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q      <= StIdle;
            last_grant_q <= GrantW'(NUM_REQ - 1);
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef APB_UART_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef APB_UART_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

endmodule
